// File: rtl/bf2_cplx_stage.sv
// bf2_cplx_stage: pipelined radix-2 complex butterfly.
//   y0 = a + b*w, y1 = a - b*w, with an optional per-beat /2 and a sticky overflow flag.
// The pipeline has three register stages:
//   S1 holds the four partial products.
//   S2 holds the rounded twiddled value t = b*w.
//   S3 holds the reduced results.
// A single global stall (adv) moves all three stages together.
// Build option BF2_SAT_EN:
//   defined   -> out-of-range results clamp to the DW-bit signed limits.
//   undefined -> out-of-range results wrap (the low DW bits are kept).
// ovf is set on out-of-range results in both builds.
module bf2_cplx_stage #(
    parameter int DW  = 16,
    parameter int TW  = 16,
    parameter int FCW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr_ovf,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic            scale,
    input  logic [DW-1:0]   a_re,
    input  logic [DW-1:0]   a_im,
    input  logic [DW-1:0]   b_re,
    input  logic [DW-1:0]   b_im,
    input  logic [TW-1:0]   w_re,
    input  logic [TW-1:0]   w_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [DW-1:0]   y0_re,
    output logic [DW-1:0]   y0_im,
    output logic [DW-1:0]   y1_re,
    output logic [DW-1:0]   y1_im,
    output logic            ovf,
    output logic [FCW-1:0]  frame_cnt
);

    // Product width: a DW x TW signed multiply fits exactly in DW+TW bits.
    localparam int PW = DW + TW;
    // Sum width: three guard bits above DW cover a +/- t, where t needs DW+2 bits.
    localparam int SW = DW + 3;
    // Round-half-up constant: half an LSB of the Q1.(TW-1) product scaling.
    localparam logic [PW:0] RND = (PW+1)'(1) << (TW-2);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Returns 1 when an SW-bit signed value is representable in DW bits signed.
    function automatic logic fits_dw(input logic [SW-1:0] v);
        return (&v[SW-1:DW-1]) || !(|v[SW-1:DW-1]);
    endfunction

    // Optional arithmetic shift right by one (truncating) at full sum width.
    function automatic logic [SW-1:0] scale_sh(input logic sc, input logic [SW-1:0] v);
        return sc ? {v[SW-1], v[SW-1:1]} : v;
    endfunction

    // Reduces an SW-bit value to DW bits: clamp or wrap, depending on the build.
    function automatic logic [DW-1:0] reduce_dw(input logic [SW-1:0] v);
`ifdef BF2_SAT_EN
        if (!fits_dw(v)) begin
            return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
        return v[DW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------

    // Stage S1
    logic            v1_q, last1_q, scale1_q;
    logic [DW-1:0]   a_re1_q, a_im1_q;
    logic [PW-1:0]   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic [PW-1:0]   p_rr_d, p_ii_d, p_ri_d, p_ir_d;

    // Stage S2
    logic            v2_q, last2_q, scale2_q;
    logic [DW-1:0]   a_re2_q, a_im2_q;
    logic [DW+1:0]   t_re_q, t_im_q;
    logic [DW+1:0]   t_re_d, t_im_d;

    // Stage S3
    logic            v3_q, last3_q;
    logic [DW-1:0]   y0_re_q, y0_im_q, y1_re_q, y1_im_q;
    logic [DW-1:0]   y0_re_d, y0_im_d, y1_re_d, y1_im_d;

    // Sticky flag and frame counter
    logic            ovf_q, ovf_d, ovf_hit;
    logic [FCW-1:0]  frame_cnt_q;

    // Global advance
    logic            adv;

    // The whole pipeline advances when the output is free or holds a bubble.
    always_comb begin
        adv = out_ready || !v3_q;
    end

    assign in_ready = adv;

    // ------------------------------------------------------------------
    // S1: full-precision partial products
    // ------------------------------------------------------------------

    // Operands are sign-extended to the product width. The low PW bits of
    // each multiply are then the exact signed product.
    logic [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;

    // Sign-extend the operands and form the four partial products.
    always_comb begin
        b_re_x = {{TW{b_re[DW-1]}}, b_re};
        b_im_x = {{TW{b_im[DW-1]}}, b_im};
        w_re_x = {{DW{w_re[TW-1]}}, w_re};
        w_im_x = {{DW{w_im[TW-1]}}, w_im};
        p_rr_d = b_re_x * w_re_x;
        p_ii_d = b_im_x * w_im_x;
        p_ri_d = b_re_x * w_im_x;
        p_ir_d = b_im_x * w_re_x;
    end

    // S1 register: accept a new beat (or a bubble) whenever the pipeline advances.
    // NOTE: the datapath registers are reset as well as the valid bits. Downstream
    // logic therefore sees zeros, never X, on y* after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            scale1_q <= 1'b0;
            a_re1_q  <= '0;
            a_im1_q  <= '0;
            p_rr_q   <= '0;
            p_ii_q   <= '0;
            p_ri_q   <= '0;
            p_ir_q   <= '0;
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignments. All stages
            // then sample the previous-cycle values of their neighbours.
            v1_q     <= in_valid;
            last1_q  <= in_last;
            scale1_q <= scale;
            a_re1_q  <= a_re;
            a_im1_q  <= a_im;
            p_rr_q   <= p_rr_d;
            p_ii_q   <= p_ii_d;
            p_ri_q   <= p_ri_d;
            p_ir_q   <= p_ir_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: twiddled value, rounded half-up, kept at DW+2 bits
    // ------------------------------------------------------------------

    logic [PW:0] sum_re, sum_im;

    // The low TW-1 bits are dropped by the rounding slice.
    logic unused_round_bits;

    // Combine the partial products, add half an LSB, and take the integer part.
    // NOTE: every always_comb output gets a value on every path (assigned
    // unconditionally here). This keeps the block free of inferred latches.
    always_comb begin
        sum_re = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q} + RND;
        sum_im = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q} + RND;
        // Selecting bits [TW-1 +: DW+2] is an arithmetic shift right by TW-1
        // (floor). The slice ends exactly at the sum MSB.
        t_re_d = sum_re[TW-1 +: DW+2];
        t_im_d = sum_im[TW-1 +: DW+2];
    end

    assign unused_round_bits = ^{sum_re[TW-2:0], sum_im[TW-2:0]};

    // S2 register: carry a, scale and last alongside the twiddled value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            scale2_q <= 1'b0;
            a_re2_q  <= '0;
            a_im2_q  <= '0;
            t_re_q   <= '0;
            t_im_q   <= '0;
        end else if (adv) begin
            v2_q     <= v1_q;
            last2_q  <= last1_q;
            scale2_q <= scale1_q;
            a_re2_q  <= a_re1_q;
            a_im2_q  <= a_im1_q;
            t_re_q   <= t_re_d;
            t_im_q   <= t_im_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: butterfly sums, optional /2, reduction to DW bits
    // ------------------------------------------------------------------

    logic [SW-1:0] s0_re, s0_im, s1_re, s1_im;

    // Form a +/- t at DW+3 bits, scale, reduce, and detect out-of-range results.
    always_comb begin
        s0_re = scale_sh(scale2_q, {{3{a_re2_q[DW-1]}}, a_re2_q} + {t_re_q[DW+1], t_re_q});
        s0_im = scale_sh(scale2_q, {{3{a_im2_q[DW-1]}}, a_im2_q} + {t_im_q[DW+1], t_im_q});
        s1_re = scale_sh(scale2_q, {{3{a_re2_q[DW-1]}}, a_re2_q} - {t_re_q[DW+1], t_re_q});
        s1_im = scale_sh(scale2_q, {{3{a_im2_q[DW-1]}}, a_im2_q} - {t_im_q[DW+1], t_im_q});

        y0_re_d = reduce_dw(s0_re);
        y0_im_d = reduce_dw(s0_im);
        y1_re_d = reduce_dw(s1_re);
        y1_im_d = reduce_dw(s1_im);

        ovf_hit = v2_q && !(fits_dw(s0_re) && fits_dw(s0_im) &&
                            fits_dw(s1_re) && fits_dw(s1_im));
    end

    // S3 register: results load only for real beats. A bubble leaves the last
    // results visible, with out_valid low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
            y0_re_q <= '0;
            y0_im_q <= '0;
            y1_re_q <= '0;
            y1_im_q <= '0;
        end else if (adv) begin
            v3_q    <= v2_q;
            last3_q <= v2_q && last2_q;
            if (v2_q) begin
                y0_re_q <= y0_re_d;
                y0_im_q <= y0_im_d;
                y1_re_q <= y1_re_d;
                y1_im_q <= y1_im_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow flag and frame counter
    // ------------------------------------------------------------------

    // Next-state logic for ovf. A new overflow loading into S3 takes priority
    // over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (adv && ovf_hit) begin
            ovf_d = 1'b1;
        end
    end

    // ovf register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Count completed frames: each output handshake that carries out_last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (v3_q && out_ready && last3_q) begin
            frame_cnt_q <= frame_cnt_q + FCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign out_valid = v3_q;
    assign out_last  = last3_q;
    assign y0_re     = y0_re_q;
    assign y0_im     = y0_im_q;
    assign y1_re     = y1_re_q;
    assign y1_im     = y1_im_q;
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;

endmodule
